// File: rtl/note_player.sv
// note_player: monophonic square-wave tone generator for the electric piano.
// Keys C4..C5 select a half period; a tick-counted tail follows key release.
module note_player #(
  parameter int RELEASE_TICKS = 64
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       tick_256,
  input  logic [7:0] keys,
  output logic       audio,
  output logic       active,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  state_t      state;
  logic [7:0]  keys_m;
  logic [7:0]  keys_s;
  logic [17:0] phase;
  logic [17:0] phase_nxt;
  logic [17:0] half;
  logic [7:0]  rel_cnt;
  logic [2:0]  enc;
  logic        any_key;
  logic        wrap;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      keys_m <= '0;
      keys_s <= '0;
    end else begin
      keys_m <= keys;
      keys_s <= keys_m;
    end
  end

  assign any_key = |keys_s;

  // lowest key wins
  always_comb begin
    enc = 3'd0;
    priority case (1'b1)
      keys_s[0]: enc = 3'd0;
      keys_s[1]: enc = 3'd1;
      keys_s[2]: enc = 3'd2;
      keys_s[3]: enc = 3'd3;
      keys_s[4]: enc = 3'd4;
      keys_s[5]: enc = 3'd5;
      keys_s[6]: enc = 3'd6;
      keys_s[7]: enc = 3'd7;
      default:   enc = 3'd0;
    endcase
  end

  always_comb begin
    half = 18'd191110;
    unique case (note_idx)
      3'd0: half = 18'd191110;
      3'd1: half = 18'd170265;
      3'd2: half = 18'd151685;
      3'd3: half = 18'd143172;
      3'd4: half = 18'd127551;
      3'd5: half = 18'd113636;
      3'd6: half = 18'd101239;
      3'd7: half = 18'd95557;
    endcase
  end

  assign wrap      = (phase == half - 18'd1);
  assign phase_nxt = wrap ? 18'd0 : phase + 18'd1;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state    <= IDLE;
      audio    <= 1'b0;
      active   <= 1'b0;
      note_idx <= 3'd0;
      phase    <= 18'd0;
      rel_cnt  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          audio <= 1'b0;
          phase <= 18'd0;
          if (any_key) begin
            state    <= PLAY;
            active   <= 1'b1;
            note_idx <= enc;
          end
        end
        PLAY: begin
          if (!any_key) begin
            if (RELEASE_TICKS == 0) begin
              state  <= IDLE;
              active <= 1'b0;
              audio  <= 1'b0;
              phase  <= 18'd0;
            end else begin
              state   <= RELEASE;
              rel_cnt <= 8'(RELEASE_TICKS);
              phase   <= phase_nxt;
              if (wrap) audio <= !audio;
            end
          end else if (enc != note_idx) begin
            note_idx <= enc;
            phase    <= 18'd0;
          end else begin
            phase <= phase_nxt;
            if (wrap) audio <= !audio;
          end
        end
        RELEASE: begin
          // a key press beats a same-cycle tick
          if (any_key) begin
            state    <= PLAY;
            note_idx <= enc;
            phase    <= 18'd0;
          end else if (tick_256 && rel_cnt <= 8'd1) begin
            state  <= IDLE;
            active <= 1'b0;
            audio  <= 1'b0;
            phase  <= 18'd0;
          end else begin
            phase <= phase_nxt;
            if (wrap) audio <= !audio;
            if (tick_256) rel_cnt <= rel_cnt - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
          audio  <= 1'b0;
        end
      endcase
    end
  end

endmodule
